aes128_round_ctrl: RTL and testbench

Sequencing controller for the iterative AES-128 encryption datapath in the aes128 benchmark. It accepts one block per valid/ready handshake and steps the shared round datapath and key-expansion register through the initial AddRoundKey, rounds 1–9 and the final round. It generates the round counter, the Rcon byte and all load/enable/select strobes, then holds the result valid until it is consumed. The round datapath (S-box, ShiftRows, MixColumns, key schedule) is outside this block and is controlled only through its ports.

---
 rtl/aes128_ctrl_pkg.sv | 19 +
 rtl/aes128_round_ctrl_if.sv | 33 +++
 rtl/aes128_rcon_gen.sv | 36 +++
 rtl/aes128_round_ctrl.sv | 118 +++++++++++
 tb/tb_aes128_round_ctrl.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes128_ctrl_pkg.sv
// Shared types and helpers for the AES-128 round sequencing controller.
package aes128_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      FINAL = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam int          NR_AES128 = 10;
   localparam logic [7:0]  RCON_INIT = 8'h01;

   // GF(2^8) multiply-by-two using the AES reduction polynomial.
   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
   endfunction

endpackage

// File: rtl/aes128_round_ctrl_if.sv
// Control bus between the round controller (master) and the AES datapath / block user (slave).
//
// Handshakes: a transfer happens in a cycle where both valid and ready are 1.
// in_valid/in_ready accepts one plaintext+key; out_valid/out_ready hands off one
// ciphertext. out_valid, once raised, stays high until the cycle out_ready is seen.
// abort is a level sampled on the clock edge and cancels the block in flight.
interface aes128_round_ctrl_if;
   logic       in_valid;
   logic       in_ready;
   logic       out_valid;
   logic       out_ready;
   logic       abort;
   logic       ld_state;
   logic       key_ld;
   logic       rnd_en;
   logic       key_en;
   logic       last_rnd;
   logic [3:0] round;
   logic [7:0] rcon;
   logic       busy;

   modport master (
      input  in_valid, out_ready, abort,
      output in_ready, out_valid, ld_state, key_ld, rnd_en, key_en,
             last_rnd, round, rcon, busy
   );

   modport slave (
      output in_valid, out_ready, abort,
      input  in_ready, out_valid, ld_state, key_ld, rnd_en, key_en,
             last_rnd, round, rcon, busy
   );
endinterface

// File: rtl/aes128_rcon_gen.sv
// Round-constant register: loads 0x01 at block start, steps by xtime each round.
module aes128_rcon_gen
   import aes128_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       load_i,
   input  logic       adv_i,
   output logic [7:0] rcon_o
);

   logic [7:0] rcon_q;
   logic [7:0] rcon_d;

   // Load has priority so a fresh block always starts from the first constant.
   always_comb begin
      rcon_d = rcon_q;
      if (load_i) begin
         rcon_d = RCON_INIT;
      end else if (adv_i) begin
         rcon_d = xtime(rcon_q);
      end
   end

   // Rcon register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rcon_q <= RCON_INIT;
      end else begin
         rcon_q <= rcon_d;
      end
   end

   assign rcon_o = rcon_q;

endmodule

// File: rtl/aes128_round_ctrl.sv
// Sequencer for the iterative AES-128 datapath: initial AddRoundKey, rounds 1-9,
// final round, then holds the result until the consumer takes it.
module aes128_round_ctrl
   import aes128_ctrl_pkg::*;
#(
   parameter int ROUND_CYC = 1,          // cycles per round, 1..8
   parameter int NR        = NR_AES128   // only 10 is meaningful
) (
   input  logic                 clk,
   input  logic                 rst,
   aes128_round_ctrl_if.master  bus,
   output state_e               dbg_state_o
);

   state_e     state_q, state_d;
   logic [3:0] round_q, round_d;
   logic [2:0] sub_q,   sub_d;

   logic       accept;
   logic       last_sub;
   logic       in_round;
   logic       step;
   logic [7:0] rcon_reg;

   // Accept only from IDLE; abort wins over in_valid, and nothing leaves reset.
   assign accept   = (state_q == IDLE) && bus.in_valid && !bus.abort && !rst;
   assign last_sub = (sub_q == 3'(ROUND_CYC - 1));
   assign in_round = (state_q == ROUND) || (state_q == FINAL);
   assign step     = in_round && last_sub;

   // Next-state logic: abort cancels everything and returns to a clean IDLE.
   always_comb begin
      state_d = state_q;
      round_d = round_q;
      sub_d   = sub_q;
      if (bus.abort) begin
         state_d = IDLE;
         round_d = 4'd0;
         sub_d   = 3'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  state_d = ROUND;
                  round_d = 4'd1;
                  sub_d   = 3'd0;
               end
            end
            ROUND: begin
               if (last_sub) begin
                  sub_d   = 3'd0;
                  round_d = round_q + 4'd1;
                  if (round_q == 4'(NR - 1)) begin
                     state_d = FINAL;
                  end
               end else begin
                  sub_d = sub_q + 3'd1;
               end
            end
            FINAL: begin
               if (last_sub) begin
                  sub_d   = 3'd0;
                  state_d = DONE;
               end else begin
                  sub_d = sub_q + 3'd1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state_d = IDLE;
                  round_d = 4'd0;
               end
            end
            default: begin
               state_d = IDLE;
               round_d = 4'd0;
               sub_d   = 3'd0;
            end
         endcase
      end
   end

   // State, round number and sub-cycle registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         round_q <= 4'd0;
         sub_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         round_q <= round_d;
         sub_q   <= sub_d;
      end
   end

   aes128_rcon_gen u_rcon (
      .clk    (clk),
      .rst    (rst),
      .load_i (accept),
      .adv_i  (step),
      .rcon_o (rcon_reg)
   );

   // in_ready is gated by rst so every output reads 0 while reset is held;
   // all other outputs besides the load strobes decode registered state only.
   assign bus.in_ready  = (state_q == IDLE) && !rst;
   assign bus.ld_state  = accept;
   assign bus.key_ld    = accept;
   assign bus.rnd_en    = step;
   assign bus.key_en    = step;
   assign bus.last_rnd  = (state_q == FINAL);
   assign bus.out_valid = (state_q == DONE);
   assign bus.round     = round_q;
   assign bus.rcon      = in_round ? rcon_reg : 8'h00;
   assign bus.busy      = (state_q != IDLE);
   assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_aes128_round_ctrl.sv
// Directed bench for aes128_round_ctrl: a cycle table for one block at ROUND_CYC=1,
// then hand sequences for backpressure, abort, ROUND_CYC=3 and mid-block reset.
module tb_aes128_round_ctrl;
   import aes128_ctrl_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   aes128_round_ctrl_if b1 ();
   aes128_round_ctrl_if b3 ();
   state_e st1, st3;

   aes128_round_ctrl #(.ROUND_CYC(1), .NR(10)) dut1 (.clk(clk), .rst(rst), .bus(b1), .dbg_state_o(st1));
   aes128_round_ctrl #(.ROUND_CYC(3), .NR(10)) dut3 (.clk(clk), .rst(rst), .bus(b3), .dbg_state_o(st3));

   // ---------------- scoreboard ----------------
   int n_vec = 0;
   int n_err = 0;
   logic [7:0] exp_q[$];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_zero1(input string p);
      chk({p, ".in_ready"},  8'(b1.in_ready),  8'h0);
      chk({p, ".out_valid"}, 8'(b1.out_valid), 8'h0);
      chk({p, ".ld_state"},  8'(b1.ld_state),  8'h0);
      chk({p, ".key_ld"},    8'(b1.key_ld),    8'h0);
      chk({p, ".rnd_en"},    8'(b1.rnd_en),    8'h0);
      chk({p, ".key_en"},    8'(b1.key_en),    8'h0);
      chk({p, ".last_rnd"},  8'(b1.last_rnd),  8'h0);
      chk({p, ".round"},     8'(b1.round),     8'h0);
      chk({p, ".rcon"},      b1.rcon,          8'h0);
      chk({p, ".busy"},      8'(b1.busy),      8'h0);
      chk({p, ".in_ready3"}, 8'(b3.in_ready),  8'h0);
   endtask

   // ---------------- driver helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic       iv, ordy, ab;
      logic       ir, ld, rnd, last, ov, busy;
      logic [3:0] rnd_no;
      logic [7:0] rc;
   } vec_t;

   vec_t tbl[13];
   logic [7:0] rcon_seq[10];

   function automatic vec_t mk(input logic iv, input logic ir, input logic ld, input logic rnd,
                               input logic last, input logic ov, input logic busy,
                               input logic [3:0] rn, input logic [7:0] rc);
      vec_t v;
      v.iv = iv; v.ordy = 1'b1; v.ab = 1'b0;
      v.ir = ir; v.ld = ld; v.rnd = rnd; v.last = last; v.ov = ov; v.busy = busy;
      v.rnd_no = rn; v.rc = rc;
      return v;
   endfunction

   initial begin
      int lat;
      int cnt;
      int nrnd;
      int nlast;
      logic [7:0] e;

      rcon_seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
      tbl[0] = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
      for (int r = 1; r <= 9; r++)
         tbl[r] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'(r), rcon_seq[r-1]);
      tbl[10] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd10, 8'h36);
      tbl[11] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd10, 8'h00);
      tbl[12] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);

      b1.in_valid = 1'b0; b1.out_ready = 1'b1; b1.abort = 1'b0;
      b3.in_valid = 1'b0; b3.out_ready = 1'b1; b3.abort = 1'b0;

      // Reset: every output low while rst is held, even with in_valid up.
      b1.in_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_zero1("reset");
      b1.in_valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      chk("post_reset.in_ready", 8'(b1.in_ready), 8'h1);
      chk("post_reset.round",    8'(b1.round),    8'h0);
      chk("post_reset.rcon",     b1.rcon,         8'h00);

      // Basic block, ROUND_CYC=1: one table row per cycle T0..T12.
      for (int i = 0; i < 13; i++) begin
         step();
         b1.in_valid = tbl[i].iv; b1.out_ready = tbl[i].ordy; b1.abort = tbl[i].ab;
         @(negedge clk);
         chk($sformatf("basic[%0d].in_ready", i),  8'(b1.in_ready),  8'(tbl[i].ir));
         chk($sformatf("basic[%0d].ld_state", i),  8'(b1.ld_state),  8'(tbl[i].ld));
         chk($sformatf("basic[%0d].key_ld", i),    8'(b1.key_ld),    8'(tbl[i].ld));
         chk($sformatf("basic[%0d].rnd_en", i),    8'(b1.rnd_en),    8'(tbl[i].rnd));
         chk($sformatf("basic[%0d].key_en", i),    8'(b1.key_en),    8'(tbl[i].rnd));
         chk($sformatf("basic[%0d].last_rnd", i),  8'(b1.last_rnd),  8'(tbl[i].last));
         chk($sformatf("basic[%0d].out_valid", i), 8'(b1.out_valid), 8'(tbl[i].ov));
         chk($sformatf("basic[%0d].busy", i),      8'(b1.busy),      8'(tbl[i].busy));
         chk($sformatf("basic[%0d].round", i),     8'(b1.round),     8'(tbl[i].rnd_no));
         chk($sformatf("basic[%0d].rcon", i),      b1.rcon,          tbl[i].rc);
      end

      // Backpressure: hold out_ready low for 5 DONE cycles.
      step();
      b1.in_valid = 1'b1; b1.out_ready = 1'b0;
      step();
      b1.in_valid = 1'b0;
      cnt = 0;
      @(negedge clk);
      while (!b1.out_valid && cnt < 30) begin
         step();
         cnt++;
         @(negedge clk);
      end
      chk("bp.reach_done", 8'(b1.out_valid), 8'h1);
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("bp[%0d].out_valid", k), 8'(b1.out_valid), 8'h1);
         chk($sformatf("bp[%0d].in_ready", k),  8'(b1.in_ready),  8'h0);
         chk($sformatf("bp[%0d].strobes", k),
             8'({b1.ld_state, b1.key_ld, b1.rnd_en, b1.key_en}), 8'h0);
         chk($sformatf("bp[%0d].round", k), 8'(b1.round), 8'd10);
         chk($sformatf("bp[%0d].rcon", k),  b1.rcon,       8'h00);
         step();
         @(negedge clk);
      end
      b1.out_ready = 1'b1;
      chk("bp.handshake.out_valid", 8'(b1.out_valid), 8'h1);
      step();
      @(negedge clk);
      chk("bp.after.in_ready",  8'(b1.in_ready),  8'h1);
      chk("bp.after.out_valid", 8'(b1.out_valid), 8'h0);

      // Abort at round 5, then confirm no out_valid appears.
      step();
      b1.in_valid = 1'b1;
      step();
      b1.in_valid = 1'b0;
      cnt = 0;
      @(negedge clk);
      while (b1.round != 4'd5 && cnt < 30) begin
         step();
         cnt++;
         @(negedge clk);
      end
      chk("abort.reach_r5", 8'(b1.round), 8'd5);
      b1.abort = 1'b1;
      step();
      b1.abort = 1'b0;
      @(negedge clk);
      chk("abort.in_ready", 8'(b1.in_ready), 8'h1);
      chk("abort.round",    8'(b1.round),    8'h0);
      chk("abort.busy",     8'(b1.busy),     8'h0);
      chk("abort.rcon",     b1.rcon,         8'h00);
      cnt = 0;
      for (int k = 0; k < 15; k++) begin
         step();
         @(negedge clk);
         if (b1.out_valid) cnt++;
      end
      chk("abort.no_out_valid", 8'(cnt), 8'h0);

      // Normal block after abort: latency T0 -> out_valid is 11.
      step();
      b1.in_valid = 1'b1;
      lat = 0;
      do begin
         step();
         b1.in_valid = 1'b0;
         lat++;
         @(negedge clk);
      end while (!b1.out_valid && lat < 40);
      chk("after_abort.latency", 8'(lat), 8'd11);

      // Abort together with in_valid in IDLE: nothing loads.
      step();
      b1.in_valid = 1'b1; b1.abort = 1'b1;
      @(negedge clk);
      chk("idle_abort.ld_state", 8'(b1.ld_state), 8'h0);
      chk("idle_abort.key_ld",   8'(b1.key_ld),   8'h0);
      step();
      b1.in_valid = 1'b0; b1.abort = 1'b0;
      @(negedge clk);
      chk("idle_abort.in_ready", 8'(b1.in_ready), 8'h1);
      chk("idle_abort.busy",     8'(b1.busy),     8'h0);
      chk("idle_abort.round",    8'(b1.round),    8'h0);

      // ROUND_CYC=3: rnd_en every third cycle with the Rcon sequence, out_valid at T0+31.
      for (int k = 0; k < 10; k++) exp_q.push_back(rcon_seq[k]);
      step();
      b3.in_valid = 1'b1;
      @(negedge clk);
      chk("rc3.ld_state", 8'(b3.ld_state), 8'h1);
      lat = 0; nrnd = 0; nlast = 0;
      do begin
         step();
         b3.in_valid = 1'b0;
         lat++;
         @(negedge clk);
         if (b3.last_rnd) nlast++;
         if (b3.rnd_en) begin
            nrnd++;
            chk($sformatf("rc3.rnd%0d.cycle", nrnd), 8'(lat), 8'(3 * nrnd));
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk($sformatf("rc3.rnd%0d.rcon", nrnd), b3.rcon, e);
            end else begin
               chk("rc3.extra_rnd_en", 8'(nrnd), 8'd10);
            end
         end
      end while (!b3.out_valid && lat < 60);
      chk("rc3.latency",   8'(lat),          8'd31);
      chk("rc3.rnd_count", 8'(nrnd),         8'd10);
      chk("rc3.last_cyc",  8'(nlast),        8'd3);
      chk("rc3.exp_left",  8'(exp_q.size()), 8'd0);
      chk("rc3.done_rcon", b3.rcon,          8'h00);

      // Reset asserted at round 7: outputs drop immediately, clean IDLE after release.
      step();
      b1.in_valid = 1'b1;
      step();
      b1.in_valid = 1'b0;
      cnt = 0;
      @(negedge clk);
      while (b1.round != 4'd7 && cnt < 30) begin
         step();
         cnt++;
         @(negedge clk);
      end
      chk("rst7.reach_r7", 8'(b1.round), 8'd7);
      #2 rst = 1'b1;
      #1;
      chk_zero1("rst7");
      step();
      rst = 1'b0;
      step();
      @(negedge clk);
      chk("rst7.after.in_ready",  8'(b1.in_ready),  8'h1);
      chk("rst7.after.round",     8'(b1.round),     8'h0);
      chk("rst7.after.rcon",      b1.rcon,          8'h00);
      chk("rst7.after.out_valid", 8'(b1.out_valid), 8'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
